// File: rtl/collect_2x1_rr_fifo_seq_if.sv
// Handshake bundle for the 2:1 round-robin FIFO collector.
// Ports: i_valid/i_data_bus/i_en in, o_in_ready/o_valid/o_data_bus/o_src/o_overflow out, i_out_ready in.
interface collect_2x1_rr_fifo_seq_if #(
    parameter int DATA_WIDTH = 32
);
    logic [1:0]              i_valid;
    logic [2*DATA_WIDTH-1:0] i_data_bus;
    logic                    i_en;
    logic [1:0]              o_in_ready;
    logic                    o_valid;
    logic [DATA_WIDTH-1:0]   o_data_bus;
    logic                    o_src;
    logic                    i_out_ready;
    logic [1:0]              o_overflow;

    modport master (
        output i_valid,
        output i_data_bus,
        output i_en,
        output i_out_ready,
        input  o_in_ready,
        input  o_valid,
        input  o_data_bus,
        input  o_src,
        input  o_overflow
    );

    modport slave (
        input  i_valid,
        input  i_data_bus,
        input  i_en,
        input  i_out_ready,
        output o_in_ready,
        output o_valid,
        output o_data_bus,
        output o_src,
        output o_overflow
    );
endinterface

// File: rtl/collect_2x1_rr_fifo_seq.sv
// Two input FIFOs merged round-robin into one registered output stage.
// Ports: clk, rst_n (async low), bus (slave modport: inputs, ready, output word, overflow).
module collect_2x1_rr_fifo_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    collect_2x1_rr_fifo_seq_if.slave    bus
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = FIFO_DEPTH + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef logic [DATA_WIDTH-1:0] word_t;
    typedef logic [AW-1:0]         ptr_t;
    typedef logic [CW-1:0]         cnt_t;

    // index 1 = high input, index 0 = low input
    word_t mem [2][FIFO_DEPTH];
    ptr_t  wr_ptr [2];
    ptr_t  rd_ptr [2];
    cnt_t  cnt [2];

    word_t      din [2];
    logic [1:0] full;
    logic [1:0] ne;
    logic [1:0] wr;
    logic [1:0] drop;
    logic [1:0] pop;
    logic       load;
    logic       gnt;
    word_t      head;

    logic       rr_ptr;
    logic       out_valid;
    word_t      out_data;
    logic       out_src;
    logic [1:0] ovf;

    // Per-FIFO status and write qualification.
    // Full is judged on pre-edge occupancy, so a
    // same-edge pop never frees room for a write.
    always_comb begin
        full = '0;
        ne   = '0;
        wr   = '0;
        drop = '0;
        for (int k = 0; k < 2; k++) begin
            din[k]  = bus.i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
            full[k] = (cnt[k] == FULL_CNT);
            ne[k]   = (cnt[k] != '0);
            wr[k]   = bus.i_en & bus.i_valid[k] & ~full[k];
            drop[k] = bus.i_en & bus.i_valid[k] & full[k];
        end
    end

    assign load = ~out_valid | bus.i_out_ready;

    // Round-robin grant from pre-edge occupancy.
    always_comb begin
        gnt = rr_ptr;
        pop = 2'b00;
        if (load) begin
            unique case (ne)
                2'b11:   gnt = rr_ptr;
                2'b10:   gnt = 1'b1;
                2'b01:   gnt = 1'b0;
                default: gnt = rr_ptr;
            endcase
            pop[1] = gnt & ne[1];
            pop[0] = ~gnt & ne[0];
        end
    end

    assign head = mem[gnt][rd_ptr[gnt]];

    // Storage needs no reset; occupancy
    // and pointers define what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (wr[k]) begin
                mem[k][wr_ptr[k]] <= din[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                wr_ptr[k] <= '0;
                rd_ptr[k] <= '0;
                cnt[k]    <= '0;
            end
            rr_ptr    <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            ovf       <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (wr[k]) begin
                    wr_ptr[k] <= wr_ptr[k] + 1'b1;
                end
                if (pop[k]) begin
                    rd_ptr[k] <= rd_ptr[k] + 1'b1;
                end
                cnt[k] <= cnt[k] + CW'(wr[k])
                                 - CW'(pop[k]);
                if (drop[k]) begin
                    ovf[k] <= 1'b1;
                end
            end
            if (load) begin
                out_valid <= |pop;
                out_data  <= (|pop) ? head : '0;
                out_src   <= pop[1];
            end
            // Pointer moves to the loser only
            // when something was granted.
            if (|pop) begin
                rr_ptr <= ~gnt;
            end
        end
    end

    assign bus.o_in_ready = ~full;
    assign bus.o_valid    = out_valid;
    assign bus.o_data_bus = out_data;
    assign bus.o_src      = out_src;
    assign bus.o_overflow = ovf;

endmodule

// File: tb/tb_collect_2x1_rr_fifo_seq.sv
// Randomized and directed bench for collect_2x1_rr_fifo_seq.
// Ports: drives the interface master side, checks against a queue-based model.
module tb_collect_2x1_rr_fifo_seq;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    collect_2x1_rr_fifo_seq_if #(.DATA_WIDTH(DW)) bus ();

    collect_2x1_rr_fifo_seq #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq_hi[$];
    logic [DW-1:0] mq_lo[$];
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic          m_src;
    logic          m_next_hi;
    logic [1:0]    m_ovf;

    task automatic model_reset();
        mq_hi.delete();
        mq_lo.delete();
        m_valid   = 1'b0;
        m_data    = '0;
        m_src     = 1'b0;
        m_next_hi = 1'b1;
        m_ovf     = 2'b00;
    endtask

    // One clock edge of the reference behaviour,
    // using the inputs currently applied.
    task automatic model_edge();
        int  sh;
        int  sl;
        bit  take;
        sh = mq_hi.size();
        sl = mq_lo.size();
        if (!rst_n) begin
            model_reset();
            return;
        end
        take = !m_valid || bus.i_out_ready;
        if (take) begin
            if (sh > 0 && (sl == 0 || m_next_hi)) begin
                m_data    = mq_hi.pop_front();
                m_valid   = 1'b1;
                m_src     = 1'b1;
                m_next_hi = 1'b0;
            end else if (sl > 0) begin
                m_data    = mq_lo.pop_front();
                m_valid   = 1'b1;
                m_src     = 1'b0;
                m_next_hi = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_data  = '0;
                m_src   = 1'b0;
            end
        end
        if (bus.i_en) begin
            if (bus.i_valid[1]) begin
                if (sh < DEPTH) mq_hi.push_back(bus.i_data_bus[2*DW-1:DW]);
                else m_ovf[1] = 1'b1;
            end
            if (bus.i_valid[0]) begin
                if (sl < DEPTH) mq_lo.push_back(bus.i_data_bus[DW-1:0]);
                else m_ovf[0] = 1'b1;
            end
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_en        = 1'b0;
        bus.i_valid     = 2'b00;
        bus.i_data_bus  = '0;
        bus.i_out_ready = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        bus.i_en        = 1'b1;
        bus.i_valid     = 2'b11;
        bus.i_data_bus  = {32'hDEAD_BEEF, 32'h1234_5678};
        bus.i_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b want 0", bus.o_valid);
        end
        n_checks++;
        if (bus.o_data_bus !== '0) begin
            n_errors++;
            $display("FAIL reset_data: got %h want 0", bus.o_data_bus);
        end
        n_checks++;
        if (bus.o_src !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_src: got %b want 0", bus.o_src);
        end
        n_checks++;
        if (bus.o_overflow !== 2'b00) begin
            n_errors++;
            $display("FAIL reset_ovf: got %b want 00", bus.o_overflow);
        end
        n_checks++;
        if (bus.o_in_ready !== 2'b11) begin
            n_errors++;
            $display("FAIL reset_in_ready: got %b want 11", bus.o_in_ready);
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (bus.o_in_ready !== 2'b11) begin
            n_errors++;
            $display("FAIL post_reset_in_ready: got %b want 11", bus.o_in_ready);
        end
    endtask

    task automatic test_single_high();
        do_reset();
        bus.i_en        = 1'b1;
        bus.i_valid     = 2'b10;
        bus.i_data_bus  = {32'h0000_00A5, 32'h0};
        bus.i_out_ready = 1'b1;
        cyc();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL single_latency: got valid %b want 0", bus.o_valid);
        end
        bus.i_valid = 2'b00;
        cyc();
        n_checks++;
        if ({bus.o_valid, bus.o_src, bus.o_data_bus} !== {1'b1, 1'b1, 32'hA5}) begin
            n_errors++;
            $display("FAIL single_word: got v%b s%b %h want v1 s1 a5",
                     bus.o_valid, bus.o_src, bus.o_data_bus);
        end
        cyc();
        n_checks++;
        if ({bus.o_valid, bus.o_data_bus} !== {1'b0, 32'h0}) begin
            n_errors++;
            $display("FAIL single_drain: got v%b %h want v0 0",
                     bus.o_valid, bus.o_data_bus);
        end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] exp_d [4];
        logic          exp_s [4];
        exp_d = '{32'h11, 32'h22, 32'h11, 32'h22};
        exp_s = '{1'b1, 1'b0, 1'b1, 1'b0};
        do_reset();
        bus.i_en        = 1'b1;
        bus.i_valid     = 2'b11;
        bus.i_data_bus  = {32'h11, 32'h22};
        bus.i_out_ready = 1'b1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if ({bus.o_valid, bus.o_src, bus.o_data_bus}
                !== {1'b1, exp_s[i], exp_d[i]}) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got v%b s%b %h want v1 s%b %h",
                         i, bus.o_valid, bus.o_src, bus.o_data_bus,
                         exp_s[i], exp_d[i]);
            end
            bus.i_valid = 2'b00;
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.i_en        = 1'b1;
        bus.i_out_ready = 1'b0;
        for (int v = 1; v <= 6; v++) begin
            bus.i_valid    = 2'b01;
            bus.i_data_bus = {32'h0, DW'(v)};
            cyc();
            n_checks++;
            if (bus.o_in_ready[0] !== (v < 5)) begin
                n_errors++;
                $display("FAIL bp_in_ready[%0d]: got %b want %b",
                         v, bus.o_in_ready[0], (v < 5));
            end
            n_checks++;
            if (bus.o_overflow[0] !== (v == 6)) begin
                n_errors++;
                $display("FAIL bp_ovf_step[%0d]: got %b want %b",
                         v, bus.o_overflow[0], (v == 6));
            end
        end
        n_checks++;
        if ({bus.o_valid, bus.o_data_bus} !== {1'b1, 32'd1}) begin
            n_errors++;
            $display("FAIL bp_hold: got v%b %h want v1 1",
                     bus.o_valid, bus.o_data_bus);
        end
        n_checks++;
        if (bus.o_overflow !== 2'b01) begin
            n_errors++;
            $display("FAIL bp_ovf: got %b want 01", bus.o_overflow);
        end
        bus.i_valid     = 2'b00;
        bus.i_out_ready = 1'b1;
        for (int v = 2; v <= 5; v++) begin
            cyc();
            n_checks++;
            if ({bus.o_valid, bus.o_data_bus} !== {1'b1, DW'(v)}) begin
                n_errors++;
                $display("FAIL bp_drain[%0d]: got v%b %h want v1 %h",
                         v, bus.o_valid, bus.o_data_bus, v);
            end
        end
        cyc();
        n_checks++;
        if (bus.o_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_no_dropped: got v%b %h want v0",
                     bus.o_valid, bus.o_data_bus);
        end
    endtask

    task automatic test_enable_gating();
        do_reset();
        bus.i_en        = 1'b0;
        bus.i_valid     = 2'b11;
        bus.i_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.i_data_bus = {$urandom(), $urandom()};
            cyc();
            n_checks++;
            if ({bus.o_valid, bus.o_overflow, bus.o_in_ready}
                !== {1'b0, 2'b00, 2'b11}) begin
                n_errors++;
                $display("FAIL gate_idle[%0d]: got v%b ovf%b rdy%b want v0 ovf00 rdy11",
                         i, bus.o_valid, bus.o_overflow, bus.o_in_ready);
            end
        end
        // Fill low FIFO, then drain with enable off and
        // valid still high: no writes, no overflow.
        bus.i_en        = 1'b1;
        bus.i_valid     = 2'b01;
        bus.i_out_ready = 1'b0;
        for (int v = 1; v <= 5; v++) begin
            bus.i_data_bus = {32'h0, DW'(v + 32'h40)};
            cyc();
        end
        bus.i_en        = 1'b0;
        bus.i_valid     = 2'b11;
        bus.i_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cyc();
            n_checks++;
            if ({bus.o_valid, bus.o_data_bus, bus.o_overflow}
                !== {m_valid, m_data, 2'b00}) begin
                n_errors++;
                $display("FAIL gate_drain[%0d]: got v%b %h ovf%b want v%b %h ovf00",
                         i, bus.o_valid, bus.o_data_bus, bus.o_overflow,
                         m_valid, m_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        bus.i_en        = 1'b1;
        bus.i_valid     = 2'b11;
        bus.i_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.i_data_bus = {DW'(i + 32'h100), DW'(i + 32'h200)};
            cyc();
        end
        n_checks++;
        if ({bus.o_valid, bus.o_overflow} !== {1'b1, 2'b11}) begin
            n_errors++;
            $display("FAIL mid_pre: got v%b ovf%b want v1 ovf11",
                     bus.o_valid, bus.o_overflow);
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({bus.o_valid, bus.o_overflow, bus.o_data_bus, bus.o_in_ready}
            !== {1'b0, 2'b00, 32'h0, 2'b11}) begin
            n_errors++;
            $display("FAIL mid_async: got v%b ovf%b %h rdy%b want v0 ovf00 0 rdy11",
                     bus.o_valid, bus.o_overflow, bus.o_data_bus, bus.o_in_ready);
        end
        #1;
        rst_n           = 1'b1;
        bus.i_valid     = 2'b00;
        bus.i_out_ready = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++;
            if (bus.o_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_stale[%0d]: got v%b %h want v0",
                         i, bus.o_valid, bus.o_data_bus);
            end
        end
        bus.i_valid    = 2'b10;
        bus.i_data_bus = {32'h77, 32'h0};
        cyc();
        bus.i_valid = 2'b00;
        cyc();
        n_checks++;
        if ({bus.o_valid, bus.o_src, bus.o_data_bus} !== {1'b1, 1'b1, 32'h77}) begin
            n_errors++;
            $display("FAIL mid_fresh: got v%b s%b %h want v1 s1 77",
                     bus.o_valid, bus.o_src, bus.o_data_bus);
        end
    endtask

    task automatic test_random();
        logic [1:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            bus.i_en        = ($urandom_range(0, 3) != 0);
            bus.i_valid     = 2'($urandom());
            bus.i_data_bus  = {$urandom(), $urandom()};
            if (i < 300) bus.i_out_ready = ($urandom_range(0, 3) != 0);
            else bus.i_out_ready = ($urandom_range(0, 2) == 0);
            cyc();
            exp_rdy = {mq_hi.size() < DEPTH, mq_lo.size() < DEPTH};
            n_checks++;
            if ({bus.o_valid, bus.o_src, bus.o_data_bus}
                !== {m_valid, m_src, m_data}) begin
                n_errors++;
                $display("FAIL rand_out[%0d]: got v%b s%b %h want v%b s%b %h",
                         i, bus.o_valid, bus.o_src, bus.o_data_bus,
                         m_valid, m_src, m_data);
            end
            n_checks++;
            if ({bus.o_overflow, bus.o_in_ready} !== {m_ovf, exp_rdy}) begin
                n_errors++;
                $display("FAIL rand_flags[%0d]: got ovf%b rdy%b want ovf%b rdy%b",
                         i, bus.o_overflow, bus.o_in_ready, m_ovf, exp_rdy);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        test_reset();
        test_single_high();
        test_simultaneous();
        test_backpressure();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
